// File: rtl/event_indicator_pkg.sv
// Shared types, default durations and width helper for the event indicator.
// Optional overflow flag is enabled by defining EVENT_INDICATOR_OVERFLOW_EN.
package event_indicator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  // 100 ms pulse and 100 ms gap at a 50 MHz clock
  localparam int DEFAULT_ON_DUR   = 5_000_000;
  localparam int DEFAULT_OFF_DUR  = 5_000_000;
  localparam int DEFAULT_MAX_PEND = 15;

  // Bits needed to hold the longer of the two dwell durations
  function automatic int timer_width(input int on_dur, input int off_dur);
    int longest;
    longest = (on_dur > off_dur) ? on_dur : off_dur;
    if (longest < 1) begin
      return 1;
    end
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/event_indicator_if.sv
// Strobe-in / indicator-out bundle of the event indicator.
// Carries the Overflow flag only when EVENT_INDICATOR_OVERFLOW_EN is defined.
interface event_indicator_if
  import event_indicator_pkg::*;
#(
  parameter int MAX_PEND = DEFAULT_MAX_PEND
);

  logic                            In;
  logic                            Out;
  logic                            Busy;
  logic                            Done;
  logic [$clog2(MAX_PEND+1)-1:0]   Pending;

`ifdef EVENT_INDICATOR_OVERFLOW_EN
  logic                            Overflow;

  modport master (
    output In,
    input  Out,
    input  Busy,
    input  Done,
    input  Pending,
    input  Overflow
  );

  modport slave (
    input  In,
    output Out,
    output Busy,
    output Done,
    output Pending,
    output Overflow
  );
`else
  modport master (
    output In,
    input  Out,
    input  Busy,
    input  Done,
    input  Pending
  );

  modport slave (
    input  In,
    output Out,
    output Busy,
    output Done,
    output Pending
  );
`endif

endinterface

// File: rtl/event_indicator_dwell_timer.sv
// Loadable down-counter used to time the indicator pulse and the dark gap.
// Holds at zero once expired; a load always wins over counting.
module dwell_timer #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/event_indicator.sv
// Turns single-cycle event strobes into fixed-length indicator pulses, each
// followed by a dark gap, queueing strobes that arrive while busy.
// Define EVENT_INDICATOR_OVERFLOW_EN to add the sticky Overflow flag.
module event_indicator
  import event_indicator_pkg::*;
#(
  parameter int ON_DUR   = DEFAULT_ON_DUR,
  parameter int OFF_DUR  = DEFAULT_OFF_DUR,
  parameter int MAX_PEND = DEFAULT_MAX_PEND
) (
  input  logic           Clk,
  input  logic           Rst,
  event_indicator_if.slave bus
);

  localparam int TW = timer_width(ON_DUR, OFF_DUR);
  localparam int PW = $clog2(MAX_PEND + 1);

  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_DUR - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_DUR - 1);
  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PEND);

  if (ON_DUR < 1) begin : g_bad_on_dur
    $error("event_indicator: ON_DUR must be at least 1");
  end
  if (OFF_DUR < 1) begin : g_bad_off_dur
    $error("event_indicator: OFF_DUR must be at least 1");
  end
  if (MAX_PEND < 1) begin : g_bad_max_pend
    $error("event_indicator: MAX_PEND must be at least 1");
  end

  state_t        state;
  state_t        next_state;
  logic [PW-1:0] pending;
  logic [PW-1:0] pending_next;
  logic          timer_load;
  logic [TW-1:0] timer_value;
  logic          timer_zero;
  logic          gap_end;
  logic          dequeue;
  logic          enqueue_req;

  dwell_timer #(
    .WIDTH (TW)
  ) u_timer (
    .Clk        (Clk),
    .Rst        (Rst),
    .load       (timer_load),
    .load_value (timer_value),
    .zero       (timer_zero)
  );

  // A strobe at the last gap cycle is always absorbed by the restart: it either
  // starts the next pulse itself or replaces the queued event being started.
  assign gap_end     = (state == GAP) && timer_zero;
  assign dequeue     = gap_end && (pending != '0);
  assign enqueue_req = (state != IDLE) && bus.In && !gap_end;

  always_comb begin
    next_state  = state;
    timer_load  = 1'b0;
    timer_value = ON_LOAD;
    case (state)
      IDLE: begin
        if (bus.In) begin
          next_state  = ON;
          timer_load  = 1'b1;
          timer_value = ON_LOAD;
        end
      end
      ON: begin
        if (timer_zero) begin
          next_state  = GAP;
          timer_load  = 1'b1;
          timer_value = OFF_LOAD;
        end
      end
      GAP: begin
        if (timer_zero) begin
          if (dequeue || bus.In) begin
            next_state  = ON;
            timer_load  = 1'b1;
            timer_value = ON_LOAD;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_comb begin
    pending_next = pending;
    if (enqueue_req && (pending != PEND_MAX)) begin
      pending_next = pending + 1'b1;
    end else if (dequeue && !bus.In) begin
      pending_next = pending - 1'b1;
    end
  end

  // All visible outputs are flops driven from the next-state decode.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= IDLE;
      pending     <= '0;
      bus.Out     <= 1'b0;
      bus.Busy    <= 1'b0;
      bus.Done    <= 1'b0;
    end else begin
      state       <= next_state;
      pending     <= pending_next;
      bus.Out     <= (next_state == ON);
      bus.Busy    <= (next_state != IDLE);
      bus.Done    <= gap_end;
    end
  end

  assign bus.Pending = pending;

`ifdef EVENT_INDICATOR_OVERFLOW_EN
  logic drop;

  assign drop = enqueue_req && (pending == PEND_MAX);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      bus.Overflow <= 1'b0;
    end else if (drop) begin
      bus.Overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_event_indicator.sv
// Directed bench for event_indicator with ON_DUR=4, OFF_DUR=3, MAX_PEND=3.
// Checks Overflow as well when EVENT_INDICATOR_OVERFLOW_EN is defined.
module tb_event_indicator;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  event_indicator_if #(.MAX_PEND(3)) bus ();

  event_indicator #(
    .ON_DUR   (4),
    .OFF_DUR  (3),
    .MAX_PEND (3)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  function automatic logic [63:0] span(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) begin
      m[i] = 1'b1;
    end
    return m;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Cycle c runs from just after one rising edge to the next; inputs for
  // cycle c are sampled at its closing edge, outputs are read mid-cycle.
  task automatic apply_stimulus(input string name, input int n,
                                input logic [63:0] rst_m, input logic [63:0] in_m,
                                input logic [63:0] out_m, input logic [63:0] busy_m,
                                input logic [63:0] done_m, input logic [63:0] p0_m,
                                input logic [63:0] p1_m, input logic [63:0] ovf_m);
    for (int c = 0; c < n; c++) begin
      Rst    = rst_m[c];
      bus.In = in_m[c];
      @(negedge Clk);
      if (c > 0) begin
        check_output($sformatf("%s.Out@%0d", name, c), 32'(bus.Out), 32'(out_m[c]));
        check_output($sformatf("%s.Busy@%0d", name, c), 32'(bus.Busy), 32'(busy_m[c]));
        check_output($sformatf("%s.Done@%0d", name, c), 32'(bus.Done), 32'(done_m[c]));
        check_output($sformatf("%s.Pending@%0d", name, c), 32'(bus.Pending),
                     32'({p1_m[c], p0_m[c]}));
`ifdef EVENT_INDICATOR_OVERFLOW_EN
        check_output($sformatf("%s.Overflow@%0d", name, c), 32'(bus.Overflow), 32'(ovf_m[c]));
`else
        if (ovf_m[c] && (c < 0)) begin
          $display("[TB] unreachable");
        end
`endif
      end
      @(posedge Clk);
      #1;
    end
  endtask

  initial begin
    logic [63:0] r;
    r = span(0, 1);
    Rst    = 1'b1;
    bus.In = 1'b0;
    @(posedge Clk);
    #1;

    apply_stimulus("reset", 4, r, span(0, 0), '0, '0, '0, '0, '0, '0);

    apply_stimulus("single", 22, r, span(10, 10),
                   span(11, 14), span(11, 17), span(18, 18), '0, '0, '0);

    apply_stimulus("burst", 35, r, span(10, 12),
                   span(11, 14) | span(18, 21) | span(25, 28), span(11, 31),
                   span(18, 18) | span(25, 25) | span(32, 32),
                   span(12, 12) | span(18, 24), span(13, 17), '0);

    apply_stimulus("saturate", 42, r, span(10, 15),
                   span(11, 14) | span(18, 21) | span(25, 28) | span(32, 35),
                   span(11, 38),
                   span(18, 18) | span(25, 25) | span(32, 32) | span(39, 39),
                   span(12, 12) | span(14, 17) | span(25, 31), span(13, 24),
                   span(15, 41));

    apply_stimulus("simul", 36, r, span(10, 11) | span(17, 17),
                   span(11, 14) | span(18, 21) | span(25, 28), span(11, 31),
                   span(18, 18) | span(25, 25) | span(32, 32),
                   span(12, 24), '0, '0);

    apply_stimulus("midrst", 30, r | span(12, 12), span(9, 11) | span(20, 20),
                   span(10, 12) | span(21, 24), span(10, 12) | span(21, 27),
                   span(28, 28), span(11, 11), span(12, 12), '0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/event_indicator.md
Name: event_indicator

Overview:
- Output-side counterpart of the key debouncer.
- Consumes single-cycle event strobes produced by the processor or control logic.
- Drives each strobe as a human-visible, fixed-length indicator pulse (LED or buzzer), followed by a guaranteed dark gap.
- Queues strobes that arrive while a pulse is playing, so no event is merged or lost until the queue saturates.

Parameters:
ON_DUR, 5_000_000, cycles Out is held high per event (100 ms at 50 MHz); must be >=1.
OFF_DUR, 5_000_000, cycles of forced low gap after each pulse; must be >=1.
MAX_PEND, 15, maximum queued events not yet started; must be >=1.

Ports:
Clk  input  1  system clock; all logic on its rising edge.
Rst  input  1  synchronous, active-high reset.
In  input  1  event strobe; every high cycle is one event.
Out  output  1  indicator drive, registered.
Busy  output  1  high while a pulse or gap is in progress, registered.
Done  output  1  one-cycle strobe on the cycle after each event's gap ends.
Pending  output  $clog2(MAX_PEND+1)  number of queued events, registered.

Behaviour:
- Reset: synchronous, active-high; one clock Clk. Rst sampled high at an edge forces the following values from the next cycle:
  - Out=0, Busy=0, Done=0, Pending=0.
  - State IDLE; timer cleared.
- Rst mid-operation: the active pulse and all queued events are discarded; Done is not asserted.
- States: IDLE, ON, GAP.
- Timer: loadable down-counter, width $clog2(max(ON_DUR,OFF_DUR)+1).
- IDLE:
  - In sampled high at cycle t -> ON; Out=1 and Busy=1 from cycle t+1.
- ON:
  - Out=1 for exactly ON_DUR cycles (t+1 .. t+ON_DUR), then GAP.
- GAP:
  - Out=0 for exactly OFF_DUR cycles (t+ON_DUR+1 .. t+ON_DUR+OFF_DUR).
  - At the final gap cycle, if Pending>0 or In is high -> ON; Out=1 in the next cycle (back-to-back, no extra idle cycle).
  - Otherwise -> IDLE.
  - In both cases Done=1 for exactly that next cycle.
- Queueing:
  - In high while in ON or GAP, and not consumed by a GAP->ON transition: Pending+1.
  - GAP->ON with Pending>0: Pending-1.
  - In high in the same cycle as a GAP->ON dequeue: Pending unchanged (net +1-1).
  - GAP->ON caused by In alone with Pending=0: Pending stays 0.
- Saturation: In while Pending==MAX_PEND and not simultaneously dequeuing -> event dropped; Pending holds.
- Busy equals (state != IDLE), registered alongside the state.
- Done timing: Done coincides with Out rising for the next event, or with Busy falling.
- Out never glitches; it is a flop output only.
- Elaboration: an ON_DUR, OFF_DUR or MAX_PEND value of 0 fails elaboration via an assertion or $error.

Optional Feature:
- Macro EVENT_INDICATOR_OVERFLOW_EN.
- Defined:
  - Adds output Overflow (1 bit, registered, reset 0).
  - Overflow is a sticky flag: set the cycle after any dropped event; cleared only by Rst.
- Undefined:
  - Port absent; dropped events are silent.
  - All other behaviour identical.

Decomposition:
- Package event_indicator_pkg:
  - State enum typedef (IDLE, ON, GAP).
  - Width helper function.
  - Localparam default durations.
- Sub-module dwell_timer:
  - Parameterised-width down-counter with synchronous load and zero flag.
  - Instantiated once; loaded with ON_DUR-1 or OFF_DUR-1 on state entry.
- Queue counter and FSM stay in the top module.

Test Plan (ON_DUR=4, OFF_DUR=3, MAX_PEND=3):
- Reset: Rst high cycles 0-1, In toggling -> Out, Busy, Done, Pending all 0 through cycle 2.
- Single event: In at cycle 10 ->
  - Out high 11-14, low 15-17; Busy high 11-17.
  - Done high only at 18; Busy 0 at 18.
- Burst: In at 10, 11, 12 ->
  - Pending 1 at 12 and 2 at 13; decrements to 1 at 18 and 0 at 25.
  - Out high 11-14, 18-21, 25-28; Done at 18, 25, 32.
- Saturation: In at cycles 10-15 ->
  - Pending rises to 3 and holds; exactly 4 pulses; Done at 18, 25, 32, 39.
  - With the macro defined: Overflow=1 from cycle 15 until Rst.
- Simultaneous: Pending=1 and In high at the final gap cycle 17 -> Pending stays 1, Out=1 at 18, Done=1 at 18.
- Reset mid-ON: Pending=2, Rst at cycle 12 -> cycle 13 Out=0, Busy=0, Pending=0, no Done; new In at 20 -> Out high 21-24.
